pipe_hazard_tracker: RTL and testbench
======================================

PIPE_HAZARD_TRACKER -- requirements
Module: pipe_hazard_tracker

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register address width.
REQ-002 SHALL have parameter FWD_DEPTH, default 3: tracked in-flight stages after issue; index 0 = execute, 1 = memory, 2 = write-back.
REQ-003 SHALL have parameter LOAD_STAGE, default 1: first stage index at which a load result is forwardable; legal range 0..FWD_DEPTH-1.
REQ-004 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-005 SHALL derive localparam SEL_W = $clog2(FWD_DEPTH+1).
REQ-006 SHALL have ports:
  i_clk  in  1  clock, all state on rising edge.
  i_arst  in  1  reset, synchronous, active-high.
  i_issue_valid  in  1  decode-stage instruction presented for issue.
  i_issue_rd  in  REG_ADDR_W  destination of issuing instruction.
  i_issue_we  in  1  issuing instruction writes rd.
  i_issue_load  in  1  issuing instruction is a load.
  i_rs1_addr  in  REG_ADDR_W  decode-stage source 1.
  i_rs2_addr  in  REG_ADDR_W  decode-stage source 2.
  i_stall_ext  in  1  cache-miss stall; freezes tracker.
  i_flush  in  1  taken branch; kills issuing instruction.
  o_fwd_rs1  out  SEL_W  0 = register file, k = forward from stage k-1.
  o_fwd_rs2  out  SEL_W  as o_fwd_rs1 for source 2.
  o_stall_issue  out  1  load-use stall request.
  o_inflight  out  SEL_W  count of valid writing entries.
  o_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-007 SHALL hold FWD_DEPTH entries {valid, we, load, rd}.
REQ-008 SHALL define advance = !i_stall_ext; when advance, entry[k+1] <= entry[k] for k = 0..FWD_DEPTH-2; oldest entry drops.
REQ-009 SHALL, when advance, load entry[0] with the issue fields if i_issue_valid && !o_stall_issue && !i_flush, else a bubble (valid=0).
REQ-010 SHALL, when !advance, hold all entries and o_stall_cnt unchanged.
REQ-011 SHALL, per source, match only valid entries with we=1, rd==rs, rs!=0.
REQ-012 SHALL select the youngest (lowest index) match; older matches ignored.
REQ-013 SHALL drive o_fwd_rsX = k+1 when youngest match at index k is non-load or k >= LOAD_STAGE; else 0.
REQ-014 SHALL assert o_stall_issue combinationally when i_issue_valid and, for either source, the youngest match is a load at k < LOAD_STAGE.
REQ-015 SHALL drive o_fwd_rsX = 0 when no match, rs==0, or o_stall_issue asserted.
REQ-016 SHALL compute forwarding independently of i_stall_ext and i_flush.
REQ-017 SHALL drive o_inflight = number of entries with valid && we, registered-state derived, no latency beyond entries.
REQ-018 SHALL increment o_stall_cnt on each advance cycle with o_stall_issue=1; saturate at 2^CNT_W-1, no wrap.
REQ-019 SHALL give i_stall_ext priority over i_flush and o_stall_issue: a flush during stall is ignored; upstream holds i_flush until advance.
REQ-020 SHALL, on simultaneous i_flush and o_stall_issue with advance, insert one bubble, not count the stall.
REQ-021 SHALL treat FWD_DEPTH=1 as legal: single execute-stage entry, SEL_W=1.

Reset
REQ-022 SHALL, while i_arst=1 at a clock edge, clear all entry valid bits, o_stall_cnt=0; reset overrides stall and flush.
REQ-023 SHALL present after reset: o_fwd_rs1=0, o_fwd_rs2=0, o_stall_issue=0, o_inflight=0.
REQ-024 SHALL discard in-flight entries on reset asserted mid-operation; no forwarding from pre-reset entries.

Verification
REQ-025 SHALL cover: issue add rd=5, next cycle rs1=5 -> o_fwd_rs1=1; next cycle -> 2; next -> 3; next -> 0.
REQ-026 SHALL cover: issue load rd=7, next cycle rs2=7 -> o_stall_issue=1 for one cycle, o_stall_cnt=1; following cycle o_fwd_rs2=2, stall 0.
REQ-027 SHALL cover: rd=3 issued twice back-to-back (add then add), rs1=3 -> o_fwd_rs1=1 (youngest wins); rd=0 writes never forward.
REQ-028 SHALL cover: i_stall_ext=1 for 4 cycles after issue rd=9 -> o_fwd_rs1=1 held throughout, o_inflight=1 constant.
REQ-029 SHALL cover: i_flush with issue rd=4 -> entry[0] bubble, later rs1=4 -> o_fwd_rs1=0; flush during i_stall_ext ignored.
REQ-030 SHALL cover: CNT_W=2, 5 load-use stalls -> o_stall_cnt saturates at 3; i_arst mid-stream -> all outputs return to REQ-023 values.

Source files
------------

// File: rtl/pipe_hazard_tracker.sv
// Tracks in-flight register writers after issue; picks forwarding sources and requests load-use stalls.
// Latency: forwarding/stall outputs are combinational from tracked state; entries advance one stage per non-stalled cycle.
// Backpressure: i_stall_ext freezes every entry and the stall counter; a load-use stall inserts a bubble at execute.
module pipe_hazard_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic                  i_issue_we,
    input  logic                  i_issue_load,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic                  i_stall_ext,
    input  logic                  i_flush,
    output logic [SEL_W-1:0]      o_fwd_rs1,
    output logic [SEL_W-1:0]      o_fwd_rs2,
    output logic                  o_stall_issue,
    output logic [SEL_W-1:0]      o_inflight,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    logic [FWD_DEPTH-1:0]  vld_q, vld_d;
    logic [FWD_DEPTH-1:0]  we_q, we_d;
    logic [FWD_DEPTH-1:0]  ld_q, ld_d;
    logic [REG_ADDR_W-1:0] rd_q [FWD_DEPTH];
    logic [REG_ADDR_W-1:0] rd_d [FWD_DEPTH];
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic             hit1, hit2, ld1, ld2, haz1, haz2, stall_issue;
    logic [SEL_W-1:0] idx1, idx2, inflight;

    // Scan oldest to youngest so the youngest matching writer is the one left standing.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        idx1 = '0;
        idx2 = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (vld_q[k] && we_q[k] && (rd_q[k] == i_rs1_addr) && (i_rs1_addr != '0)) begin
                hit1 = 1'b1;
                ld1  = ld_q[k];
                idx1 = SEL_W'(k);
            end
            if (vld_q[k] && we_q[k] && (rd_q[k] == i_rs2_addr) && (i_rs2_addr != '0)) begin
                hit2 = 1'b1;
                ld2  = ld_q[k];
                idx2 = SEL_W'(k);
            end
        end
        haz1        = hit1 && ld1 && (int'(idx1) < LOAD_STAGE);
        haz2        = hit2 && ld2 && (int'(idx2) < LOAD_STAGE);
        stall_issue = i_issue_valid && (haz1 || haz2);
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            inflight = inflight + SEL_W'(vld_q[k] & we_q[k]);
        end
    end

    assign o_stall_issue = stall_issue;
    assign o_fwd_rs1     = (hit1 && !haz1 && !stall_issue) ? idx1 + SEL_W'(1) : '0;
    assign o_fwd_rs2     = (hit2 && !haz2 && !stall_issue) ? idx2 + SEL_W'(1) : '0;
    assign o_inflight    = inflight;
    assign o_stall_cnt   = cnt_q;

    always_comb begin
        vld_d = vld_q;
        we_d  = we_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (!i_stall_ext) begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                vld_d[k] = vld_q[k-1];
                we_d[k]  = we_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            vld_d[0] = i_issue_valid && !stall_issue && !i_flush;
            we_d[0]  = i_issue_we;
            ld_d[0]  = i_issue_load;
            rd_d[0]  = i_issue_rd;
            // A flushed stalled instruction becomes a plain bubble and is not counted.
            if (stall_issue && !i_flush && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload fields are qualified by vld_q and need no reset.
    always_ff @(posedge i_clk) begin
        we_q <= we_d;
        ld_q <= ld_d;
        rd_q <= rd_d;
    end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Bench for pipe_hazard_tracker: directed scenarios plus randomized traffic against a list-of-instructions model.
module tb_pipe_hazard_tracker;

    logic       i_clk = 1'b0;
    logic       i_arst = 1'b0;
    logic       i_issue_valid = 1'b0;
    logic [4:0] i_issue_rd = '0;
    logic       i_issue_we = 1'b0;
    logic       i_issue_load = 1'b0;
    logic [4:0] i_rs1_addr = '0;
    logic [4:0] i_rs2_addr = '0;
    logic       i_stall_ext = 1'b0;
    logic       i_flush = 1'b0;
    logic [1:0] o_fwd_rs1, o_fwd_rs2, o_inflight;
    logic       o_stall_issue;
    logic [15:0] o_stall_cnt;
    logic [1:0] s_fwd_rs1, s_fwd_rs2, s_inflight, s_stall_cnt;
    logic       s_stall_issue;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    pipe_hazard_tracker dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
        .i_issue_we(i_issue_we), .i_issue_load(i_issue_load), .i_rs1_addr(i_rs1_addr),
        .i_rs2_addr(i_rs2_addr), .i_stall_ext(i_stall_ext), .i_flush(i_flush),
        .o_fwd_rs1(o_fwd_rs1), .o_fwd_rs2(o_fwd_rs2), .o_stall_issue(o_stall_issue),
        .o_inflight(o_inflight), .o_stall_cnt(o_stall_cnt)
    );

    pipe_hazard_tracker #(.CNT_W(2)) dut_sat (
        .i_clk(i_clk), .i_arst(i_arst), .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
        .i_issue_we(i_issue_we), .i_issue_load(i_issue_load), .i_rs1_addr(i_rs1_addr),
        .i_rs2_addr(i_rs2_addr), .i_stall_ext(i_stall_ext), .i_flush(i_flush),
        .o_fwd_rs1(s_fwd_rs1), .o_fwd_rs2(s_fwd_rs2), .o_stall_issue(s_stall_issue),
        .o_inflight(s_inflight), .o_stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] r1, input logic [4:0] r2, input logic se, input logic fl);
        i_issue_valid = v;
        i_issue_rd    = rd;
        i_issue_we    = we;
        i_issue_load  = ld;
        i_rs1_addr    = r1;
        i_rs2_addr    = r2;
        i_stall_ext   = se;
        i_flush       = fl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        i_arst = 1'b1;
        tick();
        i_arst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1, 2, 1, 0, 5, 6, 0, 0);
        @(negedge i_clk);
        checks++; if (o_fwd_rs1 !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs1 got %0d exp 0", o_fwd_rs1); end
        checks++; if (o_fwd_rs2 !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs2 got %0d exp 0", o_fwd_rs2); end
        checks++; if (o_stall_issue !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d exp 0", o_stall_issue); end
        checks++; if (o_inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", o_inflight); end
        checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", o_stall_cnt); end
    endtask

    task automatic test_fwd_chain();
        do_reset();
        drive(1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_fwd_rs1 !== 2'((k < 3) ? k + 1 : 0)) begin
                errors++; $display("FAIL chain_fwd_rs1[%0d] got %0d exp %0d", k, o_fwd_rs1, (k < 3) ? k + 1 : 0);
            end
            checks++;
            if (o_inflight !== 2'((k < 3) ? 1 : 0)) begin
                errors++; $display("FAIL chain_inflight[%0d] got %0d exp %0d", k, o_inflight, (k < 3) ? 1 : 0);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 7, 1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 0, 0, 7, 0, 0);
        @(negedge i_clk);
        checks++; if (o_stall_issue !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d exp 1", o_stall_issue); end
        checks++; if (o_fwd_rs2 !== 2'd0) begin errors++; $display("FAIL lu_fwd_during_stall got %0d exp 0", o_fwd_rs2); end
        tick();
        @(negedge i_clk);
        checks++; if (o_stall_issue !== 1'b0) begin errors++; $display("FAIL lu_stall_after got %0d exp 0", o_stall_issue); end
        checks++; if (o_fwd_rs2 !== 2'd2) begin errors++; $display("FAIL lu_fwd_rs2 got %0d exp 2", o_fwd_rs2); end
        checks++; if (o_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", o_stall_cnt); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++; if (o_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d exp 1", o_stall_cnt); end
        checks++; if (o_inflight !== 2'd2) begin errors++; $display("FAIL lu_inflight got %0d exp 2", o_inflight); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 3, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 3, 3, 0, 0);
        @(negedge i_clk);
        checks++; if (o_fwd_rs1 !== 2'd1) begin errors++; $display("FAIL b2b_youngest got %0d exp 1", o_fwd_rs1); end
        checks++; if (o_inflight !== 2'd2) begin errors++; $display("FAIL b2b_inflight got %0d exp 2", o_inflight); end
        do_reset();
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        checks++; if (o_fwd_rs1 !== 2'd0) begin errors++; $display("FAIL b2b_r0_fwd got %0d exp 0", o_fwd_rs1); end
        checks++; if (o_inflight !== 2'd1) begin errors++; $display("FAIL b2b_r0_inflight got %0d exp 1", o_inflight); end
    endtask

    task automatic test_stall_ext();
        do_reset();
        drive(1, 9, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 10, 1, 0, 9, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            checks++; if (o_fwd_rs1 !== 2'd1) begin errors++; $display("FAIL sx_fwd[%0d] got %0d exp 1", k, o_fwd_rs1); end
            checks++; if (o_inflight !== 2'd1) begin errors++; $display("FAIL sx_inflight[%0d] got %0d exp 1", k, o_inflight); end
            tick();
        end
        drive(0, 0, 0, 0, 9, 0, 0, 0);
        tick();
        @(negedge i_clk);
        checks++; if (o_fwd_rs1 !== 2'd2) begin errors++; $display("FAIL sx_release got %0d exp 2", o_fwd_rs1); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 4, 1, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 4, 0, 0, 0);
        @(negedge i_clk);
        checks++; if (o_fwd_rs1 !== 2'd0) begin errors++; $display("FAIL fl_killed got %0d exp 0", o_fwd_rs1); end
        checks++; if (o_inflight !== 2'd0) begin errors++; $display("FAIL fl_inflight got %0d exp 0", o_inflight); end
        drive(1, 4, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8, 1, 0, 4, 0, 1, 1);
        @(negedge i_clk);
        checks++; if (o_fwd_rs1 !== 2'd1) begin errors++; $display("FAIL fl_fwd_indep got %0d exp 1", o_fwd_rs1); end
        tick();
        drive(0, 0, 0, 0, 4, 0, 0, 0);
        @(negedge i_clk);
        checks++; if (o_fwd_rs1 !== 2'd1) begin errors++; $display("FAIL fl_stalled_hold got %0d exp 1", o_fwd_rs1); end
        checks++; if (o_inflight !== 2'd1) begin errors++; $display("FAIL fl_stalled_inflight got %0d exp 1", o_inflight); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 5; n++) begin
            drive(1, 7, 1, 1, 0, 0, 0, 0);
            tick();
            drive(1, 1, 1, 0, 0, 7, 0, 0);
            tick();
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            checks++;
            if (s_stall_cnt !== 2'((n < 3) ? n + 1 : 3)) begin
                errors++; $display("FAIL sat_cnt2[%0d] got %0d exp %0d", n, s_stall_cnt, (n < 3) ? n + 1 : 3);
            end
        end
        checks++; if (o_stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d exp 5", o_stall_cnt); end
        drive(1, 7, 1, 1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 0, 7, 7, 1, 1);
        i_arst = 1'b1;
        tick();
        i_arst = 1'b0;
        drive(1, 1, 1, 0, 7, 7, 0, 0);
        @(negedge i_clk);
        checks++; if (o_stall_issue !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %0d exp 0", o_stall_issue); end
        checks++; if (o_fwd_rs1 !== 2'd0 || o_fwd_rs2 !== 2'd0) begin errors++; $display("FAIL mid_rst_fwd got %0d/%0d exp 0/0", o_fwd_rs1, o_fwd_rs2); end
        checks++; if (o_inflight !== 2'd0) begin errors++; $display("FAIL mid_rst_inflight got %0d exp 0", o_inflight); end
        checks++; if (o_stall_cnt !== 16'd0 || s_stall_cnt !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", o_stall_cnt, s_stall_cnt); end
    endtask

    // Reference: list of the last three issue slots, youngest first; each slot is an instruction or a bubble.
    typedef struct {bit v; bit we; bit ld; int rd;} slot_t;
    slot_t hist[3];
    int    m_cnt, m_cnt2;

    function automatic int youngest_writer(int rs);
        if (rs == 0) return -1;
        for (int k = 0; k < 3; k++) begin
            if (hist[k].v && hist[k].we && hist[k].rd == rs) return k;
        end
        return -1;
    endfunction

    task automatic test_random();
        int  y1, y2, e_f1, e_f2, e_inf;
        bit  e_st, wait1, wait2;
        slot_t s;
        do_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
        m_cnt  = 0;
        m_cnt2 = 0;
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            i_arst = ($urandom_range(0, 99) == 0);
            y1    = youngest_writer(int'(i_rs1_addr));
            y2    = youngest_writer(int'(i_rs2_addr));
            wait1 = (y1 == 0) && hist[0].ld;
            wait2 = (y2 == 0) && hist[0].ld;
            e_st  = i_issue_valid && (wait1 || wait2);
            e_f1  = (y1 < 0 || wait1 || e_st) ? 0 : y1 + 1;
            e_f2  = (y2 < 0 || wait2 || e_st) ? 0 : y2 + 1;
            e_inf = 0;
            for (int k = 0; k < 3; k++) if (hist[k].v && hist[k].we) e_inf++;
            @(negedge i_clk);
            checks++; if (o_fwd_rs1 !== 2'(e_f1)) begin errors++; $display("FAIL rnd_fwd_rs1 cyc %0d got %0d exp %0d", n, o_fwd_rs1, e_f1); end
            checks++; if (o_fwd_rs2 !== 2'(e_f2)) begin errors++; $display("FAIL rnd_fwd_rs2 cyc %0d got %0d exp %0d", n, o_fwd_rs2, e_f2); end
            checks++; if (o_stall_issue !== e_st) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d exp %0d", n, o_stall_issue, e_st); end
            checks++; if (o_inflight !== 2'(e_inf)) begin errors++; $display("FAIL rnd_inflight cyc %0d got %0d exp %0d", n, o_inflight, e_inf); end
            checks++; if (o_stall_cnt !== 16'(m_cnt) || s_stall_cnt !== 2'(m_cnt2)) begin
                errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", n, o_stall_cnt, s_stall_cnt, m_cnt, m_cnt2);
            end
            @(posedge i_clk);
            if (i_arst) begin
                for (int k = 0; k < 3; k++) hist[k].v = 0;
                m_cnt  = 0;
                m_cnt2 = 0;
            end else if (!i_stall_ext) begin
                s.v  = i_issue_valid && !e_st && !i_flush;
                s.we = i_issue_we;
                s.ld = i_issue_load;
                s.rd = int'(i_issue_rd);
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = s;
                if (e_st && !i_flush) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
            #1;
        end
        i_arst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_chain();
        test_load_use();
        test_back_to_back();
        test_stall_ext();
        test_flush();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
